// File: rtl/speed_ctrl_pkg.sv
// Shared types and constants for the speed step scheduler and selector interface.
package speed_ctrl_pkg;

    localparam int unsigned LVL_W = 2;
    localparam int unsigned FB_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_PULSE,
        ST_WAIT_FB,
        ST_DWELL,
        ST_FINISH
    } state_e;

    localparam logic [1:0] LR_HOLD = 2'b00;
    localparam logic [1:0] LR_UP   = 2'b01;
    localparam logic [1:0] LR_DN   = 2'b10;

    localparam logic [LVL_W-1:0] L0 = 2'd0;
    localparam logic [LVL_W-1:0] L1 = 2'd1;
    localparam logic [LVL_W-1:0] L2 = 2'd2;
    localparam logic [LVL_W-1:0] L3 = 2'd3;

    typedef struct packed {
        logic             valid;
        logic [LVL_W-1:0] level;
    } lvl_dec_t;

    // Selector one-hot bus to level; valid=0 when the bus is not one-hot.
    function automatic lvl_dec_t onehot_to_level(input logic [FB_W-1:0] oh);
        lvl_dec_t d;
        d.valid = 1'b1;
        d.level = L0;
        case (oh)
            4'b1000: d.level = L0;
            4'b0100: d.level = L1;
            4'b0010: d.level = L2;
            4'b0001: d.level = L3;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/speed_step_sched_rr_arb2.sv
// Two-way round-robin arbiter; pointer remembers the last granted index.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant_c
);

    logic r_ptr;
    logic w_pick;

    // Grant the only valid requester, or the one not granted last on a tie.
    always_comb begin
        o_grant_c = 2'b00;
        w_pick    = i_valid[1];
        if (i_valid == 2'b11) begin
            w_pick = ~r_ptr;
        end
        if (i_en && (i_valid != 2'b00)) begin
            o_grant_c[w_pick] = 1'b1;
        end
    end

    // Pointer moves to the granted index on every accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b1;
        end else if (i_en && (i_valid != 2'b00)) begin
            r_ptr <= w_pick;
        end
    end

endmodule

// File: rtl/speed_step_sched.sv
// Ramps a 4-level one-hot speed selector toward arbitrated target requests,
// one LR pulse per step with feedback confirmation and dwell between steps.
// Optional: define SPEED_SHORTEST_PATH_EN to step the short way round (mod 4).
module speed_step_sched
    import speed_ctrl_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 8,
    parameter int unsigned FB_TIMEOUT   = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [LVL_W-1:0] req0_target,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [LVL_W-1:0] req1_target,
    output logic             req1_ready,
    input  logic [FB_W-1:0]  speed_fb,
    output logic [1:0]       LR,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LVL_W-1:0] cur_level
);

    state_e           r_state, w_state_nxt;
    logic [LVL_W-1:0] r_tgt, w_tgt_nxt;
    logic [LVL_W-1:0] r_exp, w_exp_nxt;
    logic             r_up, w_up_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_err_flag, w_err_flag_nxt;

    logic [1:0]       r_lr;
    logic             r_busy, r_done, r_err;
    logic [LVL_W-1:0] r_cur_level;

    lvl_dec_t         w_dec;
    logic [1:0]       w_grant;
    logic             w_accept;
    logic             w_arb_en;
`ifdef SPEED_SHORTEST_PATH_EN
    logic [LVL_W-1:0] w_diff;
`endif

    assign w_dec    = onehot_to_level(speed_fb);
    assign w_arb_en = (r_state == ST_IDLE) && !reset;
    assign w_accept = |w_grant;
`ifdef SPEED_SHORTEST_PATH_EN
    assign w_diff   = LVL_W'(r_tgt - w_dec.level);
`endif

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_en      (w_arb_en),
        .i_valid   ({req1_valid, req0_valid}),
        .o_grant_c (w_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    // State and working registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tgt      <= L0;
            r_exp      <= L0;
            r_up       <= 1'b0;
            r_cnt      <= '0;
            r_err_flag <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tgt      <= w_tgt_nxt;
            r_exp      <= w_exp_nxt;
            r_up       <= w_up_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err_flag <= w_err_flag_nxt;
        end
    end

    // Next-state logic for the step sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_tgt_nxt      = r_tgt;
        w_exp_nxt      = r_exp;
        w_up_nxt       = r_up;
        w_cnt_nxt      = r_cnt;
        w_err_flag_nxt = r_err_flag;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_tgt_nxt      = w_grant[1] ? req1_target : req0_target;
                    w_err_flag_nxt = 1'b0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!w_dec.valid) begin
                    w_err_flag_nxt = 1'b1;
                    w_state_nxt    = ST_FINISH;
                end else if (w_dec.level == r_tgt) begin
                    w_state_nxt = ST_FINISH;
                end else begin
`ifdef SPEED_SHORTEST_PATH_EN
                    w_up_nxt = (w_diff != L3);
`else
                    w_up_nxt = (r_tgt > w_dec.level);
`endif
                    w_exp_nxt   = w_up_nxt ? LVL_W'(w_dec.level + L1)
                                           : LVL_W'(w_dec.level - L1);
                    w_state_nxt = ST_PULSE;
                end
            end
            ST_PULSE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT_FB;
            end
            ST_WAIT_FB: begin
                if (w_dec.valid && (w_dec.level == r_exp)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DWELL;
                end else if (r_cnt == CNT_W'(FB_TIMEOUT - 1)) begin
                    w_err_flag_nxt = 1'b1;
                    w_state_nxt    = ST_FINISH;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DWELL: begin
                if (r_cnt == CNT_W'(DWELL_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_FINISH: begin
                w_err_flag_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lr        <= LR_HOLD;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cur_level <= L0;
        end else begin
            r_lr        <= (w_state_nxt == ST_PULSE) ? (w_up_nxt ? LR_UP : LR_DN) : LR_HOLD;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= (w_state_nxt == ST_FINISH);
            r_err       <= (w_state_nxt == ST_FINISH) && w_err_flag_nxt;
            r_cur_level <= w_dec.valid ? w_dec.level : r_cur_level;
        end
    end

    assign LR        = r_lr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign cur_level = r_cur_level;

endmodule

// File: tb/tb_speed_step_sched.sv
// Scoreboard bench for speed_step_sched with a behavioural selector model.
module tb_speed_step_sched;

    localparam int unsigned DW   = 8;
    localparam int unsigned FBT  = 4;
    localparam int unsigned CW   = 8;
    localparam int          STEP = DW + 3;

    typedef struct packed {
        int grant;
        bit err;
        int lat;
        int pulses;
        bit up;
        int final_lvl;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_target, req1_target;
    logic       req0_ready, req1_ready;
    logic [3:0] speed_fb;
    logic [1:0] LR;
    logic       busy, done, err;
    logic [1:0] cur_level;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   tmo_cnt = 0;
    int   tmo_seen = 0;
    bit   end_req = 1'b0;
    bit   end_done = 1'b0;

    exp_t sb[$];

    // selector model state
    int   sel_level = 0;
    int   tot_pulses = 0;
    int   freeze_at = -1;
    int   sel_preset = 0;
    bit   sel_load = 1'b0;
    bit   sel_bad = 1'b0;
    logic rst_q = 1'b0;

    // reference-model state
    int   m_level = 0;
    int   rr_last = 1;

    always #5 clk = ~clk;

    speed_step_sched #(
        .DWELL_CYCLES (DW),
        .FB_TIMEOUT   (FBT),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_target (req0_target),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_target (req1_target),
        .req1_ready  (req1_ready),
        .speed_fb    (speed_fb),
        .LR          (LR),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cur_level   (cur_level)
    );

    // Selector: registers LR each edge, wraps mod 4; can be frozen or preset.
    always @(posedge clk) begin
        rst_q <= reset;
        if (reset) begin
            sel_level  <= 0;
            tot_pulses <= 0;
        end else if (sel_load) begin
            sel_level <= sel_preset;
        end else if (LR == 2'b01 || LR == 2'b10) begin
            tot_pulses <= tot_pulses + 1;
            if (freeze_at < 0 || tot_pulses < freeze_at)
                sel_level <= (LR == 2'b01) ? (sel_level + 1) % 4 : (sel_level + 3) % 4;
        end
    end

    assign speed_fb = sel_bad ? 4'b0110 : 4'(4'b1000 >> sel_level);

    // Expected outcome of one request from the level rules alone.
    function automatic exp_t predict(input int grant, input int start, input int tgt,
                                     input bit bad, input int frz);
        exp_t e;
        int   n;
        bit   up;
        int   lvl;
        int   k;
`ifdef SPEED_SHORTEST_PATH_EN
        int   d;
        d  = (tgt - start + 4) % 4;
        up = (d != 3);
        n  = (d == 3) ? 1 : d;
`else
        up = (tgt > start);
        n  = up ? (tgt - start) : (start - tgt);
`endif
        e.grant = grant;
        e.up    = up;
        if (bad) begin
            e.err = 1'b1; e.lat = 2; e.pulses = 0; e.final_lvl = start;
        end else if (frz >= 0 && n > frz) begin
            k   = frz;
            lvl = start;
            for (int i = 0; i < k; i++) lvl = up ? (lvl + 1) % 4 : (lvl + 3) % 4;
            e.err = 1'b1; e.lat = 3 + FBT + STEP * k; e.pulses = k + 1; e.final_lvl = lvl;
        end else begin
            e.err = 1'b0; e.lat = 2 + STEP * n; e.pulses = n; e.final_lvl = tgt;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: checks every DUT output event against the scoreboard head.
    initial begin : monitor
        int   cyc = 0;
        int   acc_cyc = 0;
        int   acc_idx = 0;
        int   npulse = 0;
        int   last_pulse = 0;
        bit   inflight = 1'b0;
        bit   post_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (tmo_cnt != tmo_seen) begin
                chk("wait_timeout", tmo_cnt - tmo_seen, 0);
                tmo_seen = tmo_cnt;
            end
            if (end_req && !end_done) begin
                chk("sb_drained", sb.size(), 0);
                end_done = 1'b1;
            end
            if (rst_q) begin
                chk("reset_outputs", int'({LR, busy, done, err, cur_level}), 0);
                if (reset) chk("reset_ready", int'({req0_ready, req1_ready}), 0);
                inflight  = 1'b0;
                post_done = 1'b0;
            end else begin
                if (req0_ready || req1_ready) begin
                    chk("ready_rules", int'({busy, req0_ready & req1_ready,
                                            req0_ready & ~req0_valid,
                                            req1_ready & ~req1_valid}), 0);
                    inflight = 1'b1;
                    acc_cyc  = cyc;
                    acc_idx  = req1_ready ? 1 : 0;
                    npulse   = 0;
                end
                if (err && !done) chk("err_without_done", int'(err), 0);
                if (LR != 2'b00) begin
                    if (!inflight || sb.size() == 0) begin
                        chk("lr_unexpected", int'(LR), 0);
                    end else begin
                        chk("lr_dir", int'(LR), sb[0].up ? 1 : 2);
                        if (npulse == 0) chk("first_pulse_delay", cyc - acc_cyc, 2);
                        else             chk("pulse_spacing", cyc - last_pulse, STEP);
                        npulse++;
                        last_pulse = cyc;
                    end
                end
                if (done) begin
                    if (sb.size() == 0 || !inflight) begin
                        chk("done_unexpected", int'(done), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("grant", acc_idx, e.grant);
                        chk("err", int'(err), int'(e.err));
                        chk("latency", cyc - acc_cyc, e.lat);
                        chk("pulses", npulse, e.pulses);
                        chk("final_level", int'(cur_level), e.final_lvl);
                        chk("busy_at_done", int'(busy), 1);
                    end
                    inflight  = 1'b0;
                    post_done = 1'b1;
                end else if (post_done) begin
                    chk("busy_after_done", int'(busy), 0);
                    post_done = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preset(input int lvl);
        sel_preset = lvl;
        sel_load   = 1'b1;
        tick(1);
        sel_load   = 1'b0;
        m_level    = lvl;
        tick(1);
    endtask

    // Present requests, push the predicted response, wait for accept and done.
    task automatic issue(input bit v0, input int t0, input bit v1, input int t1,
                         input bit bad, input int frz, output int got);
        int   w;
        exp_t e;
        bit   hit;
        int   budget;
        got = -1;
        if (v0 && v1) w = (rr_last == 0) ? 1 : 0;
        else          w = v1 ? 1 : 0;
        rr_last = w;
        e = predict(w, m_level, (w == 1) ? t1 : t0, bad, frz);
        sb.push_back(e);
        m_level     = e.final_lvl;
        sel_bad     = bad;
        freeze_at   = (frz < 0) ? -1 : tot_pulses + frz;
        req0_valid  = v0;
        req0_target = 2'(t0);
        req1_valid  = v1;
        req1_target = 2'(t1);
        hit = 1'b0;
        budget = 0;
        while (!hit && budget < 8) begin
            @(negedge clk);
            if (req0_ready)      begin hit = 1'b1; got = 0; end
            else if (req1_ready) begin hit = 1'b1; got = 1; end
            budget++;
        end
        @(posedge clk);
        #1;
        if (!hit) begin
            tmo_cnt++;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            sb.delete();
            sel_bad   = 1'b0;
            freeze_at = -1;
            return;
        end
        if (got == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
        hit = 1'b0;
        budget = 0;
        while (!hit && budget < 200) begin
            @(negedge clk);
            if (done) hit = 1'b1;
            budget++;
        end
        if (!hit) tmo_cnt++;
        @(posedge clk);
        #1;
        sel_bad   = 1'b0;
        freeze_at = -1;
    endtask

    initial begin : driver
        int   got;
        bit   p0, p1, bad, hit;
        int   pt0, pt1, frz, budget;
        exp_t e;
        reset       = 1'b1;
        req0_valid  = 1'b1;
        req0_target = 2'd2;
        req1_valid  = 1'b0;
        req1_target = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        reset      = 1'b0;
        tick(2);

        // monotonic ramp L0 -> L2
        issue(1'b1, 2, 1'b0, 0, 1'b0, -1, got);
        // from L3 down to L0 (one wrapping up step in shortest-path builds)
        preset(3);
        issue(1'b0, 0, 1'b1, 0, 1'b0, -1, got);
        // simultaneous requests, twice in a row
        issue(1'b1, 1, 1'b1, 3, 1'b0, -1, got);
        issue(1'b1, 2, 1'b1, 3, 1'b0, -1, got);
        issue(1'b1, 2, 1'b0, 0, 1'b0, -1, got);
        // frozen feedback on the first and on the second step
        preset(0);
        issue(1'b1, 2, 1'b0, 0, 1'b0, 0, got);
        issue(1'b0, 0, 1'b1, 3, 1'b0, 1, got);
        // target equals current level
        preset(1);
        issue(1'b0, 0, 1'b1, 1, 1'b0, -1, got);
        // corrupt feedback bus
        issue(1'b1, 3, 1'b0, 0, 1'b1, -1, got);

        // reset while dwelling mid-ramp
        e = predict(0, m_level, 3, 1'b0, -1);
        sb.push_back(e);
        req0_valid  = 1'b1;
        req0_target = 2'd3;
        hit = 1'b0;
        budget = 0;
        while (!hit && budget < 8) begin
            @(negedge clk);
            if (req0_ready) hit = 1'b1;
            budget++;
        end
        if (!hit) tmo_cnt++;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        hit = 1'b0;
        budget = 0;
        while (!hit && budget < 8) begin
            @(negedge clk);
            if (LR != 2'b00) hit = 1'b1;
            budget++;
        end
        if (!hit) tmo_cnt++;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        m_level = 0;
        rr_last = 1;
        tick(2);
        reset = 1'b0;
        tick(2);
        issue(1'b0, 0, 1'b1, 1, 1'b0, -1, got);

        // randomized traffic with held losing requests
        p0 = 1'b0; p1 = 1'b0; pt0 = 0; pt1 = 0;
        for (int i = 0; i < 25; i++) begin
            if (!p0 && $urandom_range(0, 1) == 1) begin p0 = 1'b1; pt0 = int'($urandom_range(0, 3)); end
            if (!p1 && $urandom_range(0, 1) == 1) begin p1 = 1'b1; pt1 = int'($urandom_range(0, 3)); end
            if (!p0 && !p1) begin p0 = 1'b1; pt0 = int'($urandom_range(0, 3)); end
            bad = ($urandom_range(0, 9) == 0);
            frz = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
            issue(p0, pt0, p1, pt1, bad, frz, got);
            if (got == 0)      p0 = 1'b0;
            else if (got == 1) p1 = 1'b0;
            else begin p0 = 1'b0; p1 = 1'b0; end
        end
        if (p0 || p1) issue(p0, pt0, p1, pt1, 1'b0, -1, got);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        tick(4);
        end_req = 1'b1;
        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
